// File: rtl/vga_sprite_mixer.sv
// Two-stage sprite overlay: stage 1 picks the lowest-index sprite whose box covers
// (x,y) and addresses its bitmap row; stage 2 decides opacity. Optional macro: VGA_SPRITE_MIXER_BORDER_EN.
module vga_sprite_mixer #(
    parameter int NSPR  = 4,
    parameter int SPR_W = 16,
    parameter int SPR_H = 16,
    parameter int CW    = 2,
    localparam int AW   = $clog2(NSPR) + $clog2(SPR_H)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_pulse,
    input  logic                   pxl_en,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic [10*NSPR-1:0]     spr_x,
    input  logic [10*NSPR-1:0]     spr_y,
    input  logic [NSPR-1:0]        spr_en,
    input  logic [3*CW*NSPR-1:0]   spr_col,
    output logic [AW-1:0]          rom_addr,
    input  logic [SPR_W-1:0]       rom_data,
    output logic [CW-1:0]          r,
    output logic [CW-1:0]          g,
    output logic [CW-1:0]          b
);

    localparam int SW = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam int OW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = $clog2(SPR_H);
    localparam int PW = 3 * CW;

    logic [10*NSPR-1:0] sx_q, sy_q;
    logic [NSPR-1:0]    sen_q;
    logic [PW*NSPR-1:0] scol_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q   <= '0;
            sy_q   <= '0;
            sen_q  <= '0;
            scol_q <= '0;
        end else if (frame_pulse) begin
            sx_q   <= spr_x;
            sy_q   <= spr_y;
            sen_q  <= spr_en;
            scol_q <= spr_col;
        end
    end

    // ---- stage 0 -> 1: bounding-box hit test against shadow attributes ----
    logic [9:0]      dx_w [NSPR];
    logic [9:0]      dy_w [NSPR];
    logic [NSPR-1:0] box_w;

    always_comb begin
        for (int i = 0; i < NSPR; i++) begin
            dx_w[i]  = x - sx_q[10*i +: 10];
            dy_w[i]  = y - sy_q[10*i +: 10];
            box_w[i] = sen_q[i] && (dx_w[i] < 10'(SPR_W)) && (dy_w[i] < 10'(SPR_H));
        end
    end

    logic          hit_d;
    logic [SW-1:0] idx_d;
    logic [OW-1:0] off_d;
    logic [RW-1:0] row_d;
    logic [PW-1:0] col_d;

    // Walk downward so the lowest-index covering sprite is the one left standing.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        off_d = '0;
        row_d = '0;
        col_d = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (box_w[i]) begin
                hit_d = 1'b1;
                idx_d = SW'(i);
                off_d = dx_w[i][OW-1:0];
                row_d = dy_w[i][RW-1:0];
                col_d = scol_q[PW*i +: PW];
            end
        end
    end

    logic          hit_p1_q;
    logic [OW-1:0] off_p1_q;
    logic [PW-1:0] col_p1_q;
    logic          vld_p1_q;
    logic [AW-1:0] rom_addr_q;
`ifdef VGA_SPRITE_MIXER_BORDER_EN
    logic          border_d;
    logic          border_p1_q;
    assign border_d = pxl_en && ((y < 10'd8) || (y > 10'd471));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_p1_q   <= 1'b0;
            off_p1_q   <= '0;
            col_p1_q   <= '0;
            vld_p1_q   <= 1'b0;
            rom_addr_q <= '0;
`ifdef VGA_SPRITE_MIXER_BORDER_EN
            border_p1_q <= 1'b0;
`endif
        end else begin
            hit_p1_q <= hit_d;
            off_p1_q <= off_d;
            col_p1_q <= col_d;
            vld_p1_q <= pxl_en;
            if (hit_d)
                rom_addr_q <= AW'({idx_d, row_d});
`ifdef VGA_SPRITE_MIXER_BORDER_EN
            border_p1_q <= border_d;
`endif
        end
    end

    assign rom_addr = rom_addr_q;

    // ---- stage 1 -> 2: bitmap opacity and colour select ----
    logic [SPR_W-1:0] rom_rev;
    logic             opaque;
    logic [PW-1:0]    pix_d;
    logic [PW-1:0]    pix_q;

    always_comb begin
        for (int i = 0; i < SPR_W; i++)
            rom_rev[i] = rom_data[SPR_W-1-i];
    end

    assign opaque = hit_p1_q && rom_rev[off_p1_q];

    always_comb begin
        pix_d = '0;
        if (vld_p1_q) begin
            if (opaque)
                pix_d = col_p1_q;
`ifdef VGA_SPRITE_MIXER_BORDER_EN
            else if (border_p1_q)
                pix_d = '1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pix_q <= '0;
        else
            pix_q <= pix_d;
    end

    assign r = pix_q[3*CW-1:2*CW];
    assign g = pix_q[2*CW-1:CW];
    assign b = pix_q[CW-1:0];

endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Directed bench for vga_sprite_mixer: a reference model pushes expected pixels to a
// queue as stimulus is driven; they are popped two cycles later and compared.
module tb_vga_sprite_mixer;

    localparam int NSPR  = 4;
    localparam int SPR_W = 16;
    localparam int SPR_H = 16;
    localparam int CW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_pulse = 1'b0;
    logic        pxl_en = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [39:0] spr_x = '0;
    logic [39:0] spr_y = '0;
    logic [3:0]  spr_en = '0;
    logic [23:0] spr_col = '0;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data;
    logic [1:0]  r, g, b;

    logic [15:0] rom [64];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    vga_sprite_mixer #(.NSPR(NSPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .CW(CW)) dut (
        .clk(clk), .rst(rst), .frame_pulse(frame_pulse), .pxl_en(pxl_en),
        .x(x), .y(y), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
        .spr_col(spr_col), .rom_addr(rom_addr), .rom_data(rom_data),
        .r(r), .g(g), .b(b)
    );

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q [$];
    logic [9:0] m_x [4];
    logic [9:0] m_y [4];
    logic       m_en [4];
    logic [5:0] m_col [4];
    logic [5:0] pend_addr = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [9:0] px, input logic [9:0] py, input logic pe,
                                  output logic [5:0] col, output logic hit, output logic [5:0] addr);
        int sel;
        int bitpos;
        logic [9:0] dx, dy, sdx;
        logic [15:0] word;
        col = '0; hit = 1'b0; addr = '0; sel = 0; sdx = '0;
        for (int i = 0; i < NSPR; i++) begin
            dx = px - m_x[i];
            dy = py - m_y[i];
            if (!hit && m_en[i] && dx < 10'd16 && dy < 10'd16) begin
                hit = 1'b1; sel = i; sdx = dx;
                addr = 6'(i * 16 + int'(dy));
            end
        end
        word = rom[addr];
        bitpos = 15 - int'(sdx);
        if (hit && word[bitpos])
            col = m_col[sel];
`ifdef VGA_SPRITE_MIXER_BORDER_EN
        else if (pe && (py < 10'd8 || py > 10'd471))
            col = 6'h3F;
`endif
        if (!pe)
            col = '0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NSPR; i++) begin
            m_x[i] = '0; m_y[i] = '0; m_en[i] = 1'b0; m_col[i] = '0;
        end
        pend_addr = '0;
    endtask

    task automatic set_spr(input int i, input logic [9:0] sx, input logic [9:0] sy,
                           input logic en, input logic [5:0] col);
        spr_x[i*10 +: 10] = sx;
        spr_y[i*10 +: 10] = sy;
        spr_en[i]         = en;
        spr_col[i*6 +: 6] = col;
    endtask

    task automatic step(input logic [9:0] px, input logic [9:0] py, input logic pe,
                        input logic fp, input string tag);
        logic [5:0] c;
        logic       h;
        logic [5:0] a;
        @(posedge clk); #1;
        if (exp_q.size() >= 2)
            chk({tag, " pix"}, 16'({r, g, b}), 16'(exp_q.pop_front()));
        chk({tag, " addr"}, 16'(rom_addr), 16'(pend_addr));
        x = px; y = py; pxl_en = pe; frame_pulse = fp;
        model(px, py, pe, c, h, a);
        exp_q.push_back(c);
        if (h)
            pend_addr = a;
        if (fp) begin
            for (int i = 0; i < NSPR; i++) begin
                m_x[i]   = spr_x[i*10 +: 10];
                m_y[i]   = spr_y[i*10 +: 10];
                m_en[i]  = spr_en[i];
                m_col[i] = spr_col[i*6 +: 6];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(10'd0, 10'd0, 1'b0, 1'b0, "idle");
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            rom[i] = 16'($urandom);
        clear_model();

        // reset state
        #12;
        chk("rst rgb", 16'({r, g, b}), 16'h0);
        chk("rst addr", 16'(rom_addr), 16'h0);
        @(negedge clk) rst = 1'b0;

        // enables presented but never latched: whole frame stays black
        set_spr(0, 10'd0, 10'd0, 1'b1, 6'h3F);
        set_spr(1, 10'd320, 10'd240, 1'b1, 6'h2A);
        set_spr(2, 10'd600, 10'd400, 1'b1, 6'h15);
        set_spr(3, 10'd16, 10'd8, 1'b1, 6'h0F);
        for (int i = 0; i < 64; i++)
            rom[i] = 16'hFFFF;
        for (int yy = 0; yy < 480; yy += 8)
            for (int xx = 0; xx < 640; xx += 16)
                step(10'(xx), 10'(yy), 1'b1, 1'b0, "sweep");
        idle(2);

        // single sprite, colour 3/0/0, solid bitmap
        set_spr(0, 10'd100, 10'd50, 1'b1, 6'b110000);
        for (int i = 1; i < NSPR; i++)
            set_spr(i, 10'd0, 10'd0, 1'b0, 6'h0);
        step(10'd0, 10'd0, 1'b0, 1'b1, "pulse0");
        step(10'd100, 10'd50, 1'b1, 1'b0, "s0 tl");
        step(10'd116, 10'd50, 1'b1, 1'b0, "s0 right");
        step(10'd99, 10'd50, 1'b1, 1'b0, "s0 left");
        step(10'd115, 10'd65, 1'b1, 1'b0, "s0 br");
        step(10'd115, 10'd66, 1'b1, 1'b0, "s0 below");
        step(10'd100, 10'd49, 1'b1, 1'b0, "s0 above");
        step(10'd105, 10'd55, 1'b0, 1'b0, "s0 blank");
        idle(2);

        // overlapping sprites: transparent sprite 0 still wins over opaque sprite 1
        for (int i = 0; i < 64; i++)
            rom[i] = 16'($urandom);
        rom[0]  = 16'h0000;
        rom[1]  = 16'hFFFF;
        rom[16] = 16'hFFFF;
        set_spr(0, 10'd200, 10'd200, 1'b1, 6'b001100);
        set_spr(1, 10'd200, 10'd200, 1'b1, 6'b000011);
        set_spr(2, 10'd205, 10'd195, 1'b1, 6'b101010);
        set_spr(3, 10'd500, 10'd300, 1'b1, 6'b111111);
        step(10'd101, 10'd51, 1'b1, 1'b1, "pulse+pix old");
        step(10'd200, 10'd200, 1'b1, 1'b0, "overlap bg");
        step(10'd215, 10'd200, 1'b1, 1'b0, "overlap row0");
        step(10'd201, 10'd201, 1'b1, 1'b0, "overlap row1");
        step(10'd210, 10'd196, 1'b1, 1'b0, "s2 only");
        for (int k = 0; k < 200; k++)
            step(10'($urandom_range(228, 188)), 10'($urandom_range(228, 188)), 1'($urandom_range(1, 0) | (k % 3 != 0)), 1'b0, "rand");
        step(10'd505, 10'd310, 1'b1, 1'b0, "s3");

        // attribute change without a frame pulse is invisible until the pulse
        set_spr(0, 10'd300, 10'd200, 1'b1, 6'b001100);
        step(10'd200, 10'd201, 1'b1, 1'b0, "move pre a");
        step(10'd300, 10'd201, 1'b1, 1'b0, "move pre b");
        step(10'd0, 10'd0, 1'b0, 1'b1, "pulse move");
        step(10'd300, 10'd201, 1'b1, 1'b0, "move post a");
        step(10'd200, 10'd201, 1'b1, 1'b0, "move post b");
        step(10'd305, 10'd203, 1'b1, 1'b0, "move post c");
        idle(2);

        // horizontal wrap past column 1023
        for (int i = 0; i < 16; i++)
            rom[i] = 16'hFFFF;
        set_spr(0, 10'd1020, 10'd10, 1'b1, 6'b110110);
        for (int i = 1; i < NSPR; i++)
            set_spr(i, 10'd0, 10'd0, 1'b0, 6'h0);
        step(10'd0, 10'd0, 1'b0, 1'b1, "pulse wrap");
        for (int k = -4; k < 16; k++)
            step(10'(1020 + k), 10'd10, 1'b1, 1'b0, "wrap");
        step(10'd5, 10'd9, 1'b1, 1'b0, "wrap above");

        // border rows
        step(10'd300, 10'd5, 1'b1, 1'b0, "border 5");
        step(10'd300, 10'd7, 1'b1, 1'b0, "border 7");
        step(10'd300, 10'd8, 1'b1, 1'b0, "border 8");
        step(10'd300, 10'd471, 1'b1, 1'b0, "border 471");
        step(10'd300, 10'd472, 1'b1, 1'b0, "border 472");
        step(10'd300, 10'd5, 1'b0, 1'b0, "border off");
        idle(2);

        // mid-line reset discards in-flight pixels and clears shadows
        set_spr(0, 10'd50, 10'd20, 1'b1, 6'b111100);
        step(10'd0, 10'd0, 1'b0, 1'b1, "pulse pre-rst");
        step(10'd50, 10'd20, 1'b1, 1'b0, "pre-rst a");
        step(10'd51, 10'd21, 1'b1, 1'b0, "pre-rst b");
        step(10'd52, 10'd22, 1'b1, 1'b0, "pre-rst c");
        @(posedge clk); #3;
        rst = 1'b1; pxl_en = 1'b0; frame_pulse = 1'b0;
        #1;
        chk("midrst rgb", 16'({r, g, b}), 16'h0);
        chk("midrst addr", 16'(rom_addr), 16'h0);
        exp_q.delete();
        clear_model();
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        step(10'd50, 10'd20, 1'b1, 1'b0, "post-rst a");
        step(10'd53, 10'd23, 1'b1, 1'b0, "post-rst b");
        step(10'd0, 10'd0, 1'b0, 1'b1, "pulse post-rst");
        step(10'd50, 10'd20, 1'b1, 1'b0, "post-rst c");
        step(10'd60, 10'd30, 1'b1, 1'b0, "post-rst d");
        step(10'd66, 10'd20, 1'b1, 1'b0, "post-rst e");
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
